// File: rtl/parking_sensor_fsm.sv
// Parking-lot gate sensor conditioning (synchronise + debounce) and passage decoder.
// Emits registered one-cycle enter/exit pulses for completed car passages.
module parking_sensor_fsm #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       outer_raw,
  input  logic       inner_raw,
  output logic       enter,
  output logic       exit,
  output logic       outer_led,
  output logic       inner_led,
  output logic       busy,
  output logic [2:0] state_dbg
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_EN1   = 3'd1,
    S_EN2   = 3'd2,
    S_EN3   = 3'd3,
    S_EX1   = 3'd4,
    S_EX2   = 3'd5,
    S_EX3   = 3'd6,
    S_BLOCK = 3'd7
  } state_t;

  // Index 1 = outer sensor, index 0 = inner sensor throughout.
  logic [1:0]             w_raw;
  logic [1:0]             w_synced;
  logic [SYNC_STAGES-1:0] r_sync [2];
  logic [CW-1:0]          r_cnt  [2];
  logic [1:0]             r_filt;

  state_t r_state;
  state_t w_next;
  logic   w_enter_nxt;
  logic   w_exit_nxt;
  logic   r_enter;
  logic   r_exit;

  assign w_raw = {outer_raw, inner_raw};

  always_comb begin
    w_synced = '0;
    for (int unsigned k = 0; k < 2; k++) begin
      w_synced[k] = r_sync[k][SYNC_STAGES-1];
    end
  end

  // Filtered value follows the synced value only after DEBOUNCE_CYCLES consecutive mismatches.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned k = 0; k < 2; k++) begin
        r_sync[k] <= '0;
        r_cnt[k]  <= '0;
      end
      r_filt <= '0;
    end else begin
      for (int unsigned k = 0; k < 2; k++) begin
        r_sync[k] <= {r_sync[k][SYNC_STAGES-2:0], w_raw[k]};
        if (w_synced[k] != r_filt[k]) begin
          if (r_cnt[k] == CNT_LAST) begin
            r_filt[k] <= w_synced[k];
            r_cnt[k]  <= '0;
          end else begin
            r_cnt[k] <= r_cnt[k] + 1'b1;
          end
        end else begin
          r_cnt[k] <= '0;
        end
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    w_enter_nxt = 1'b0;
    w_exit_nxt  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        case (r_filt)
          2'b10:   w_next = S_EN1;
          2'b01:   w_next = S_EX1;
          2'b11:   w_next = S_BLOCK;
          default: w_next = S_IDLE;
        endcase
      end
      S_EN1: begin
        case (r_filt)
          2'b10:   w_next = S_EN1;
          2'b11:   w_next = S_EN2;
          2'b00:   w_next = S_IDLE;
          default: w_next = S_BLOCK;
        endcase
      end
      S_EN2: begin
        case (r_filt)
          2'b11:   w_next = S_EN2;
          2'b01:   w_next = S_EN3;
          2'b10:   w_next = S_EN1;
          default: w_next = S_BLOCK;
        endcase
      end
      S_EN3: begin
        case (r_filt)
          2'b01:   w_next = S_EN3;
          2'b00: begin
            w_next      = S_IDLE;
            w_enter_nxt = 1'b1;
          end
          2'b11:   w_next = S_EN2;
          default: w_next = S_BLOCK;
        endcase
      end
      S_EX1: begin
        case (r_filt)
          2'b01:   w_next = S_EX1;
          2'b11:   w_next = S_EX2;
          2'b00:   w_next = S_IDLE;
          default: w_next = S_BLOCK;
        endcase
      end
      S_EX2: begin
        case (r_filt)
          2'b11:   w_next = S_EX2;
          2'b10:   w_next = S_EX3;
          2'b01:   w_next = S_EX1;
          default: w_next = S_BLOCK;
        endcase
      end
      S_EX3: begin
        case (r_filt)
          2'b10:   w_next = S_EX3;
          2'b00: begin
            w_next     = S_IDLE;
            w_exit_nxt = 1'b1;
          end
          2'b11:   w_next = S_EX2;
          default: w_next = S_BLOCK;
        endcase
      end
      S_BLOCK: begin
        if (r_filt == 2'b00) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_enter <= 1'b0;
      r_exit  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_enter <= w_enter_nxt;
      r_exit  <= w_exit_nxt;
    end
  end

  assign enter     = r_enter;
  assign exit      = r_exit;
  assign outer_led = r_filt[1];
  assign inner_led = r_filt[0];
  assign busy      = (r_state != S_IDLE);
  assign state_dbg = r_state;

endmodule

// File: tb/tb_parking_sensor_fsm.sv
// Scoreboarded bench for parking_sensor_fsm: directed gate scenarios plus random sensor traffic,
// checked against a track-position model of car passages.
module tb_parking_sensor_fsm;

  localparam int SYNC = 2;
  localparam int DEB  = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       outer_raw = 1'b0;
  logic       inner_raw = 1'b0;
  logic       enter;
  logic       exit;
  logic       outer_led;
  logic       inner_led;
  logic       busy;
  logic [2:0] state_dbg;

  parking_sensor_fsm #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .outer_raw(outer_raw),
    .inner_raw(inner_raw),
    .enter    (enter),
    .exit     (exit),
    .outer_led(outer_led),
    .inner_led(inner_led),
    .busy     (busy),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int cyc;
    bit is_enter;
  } pulse_t;
  pulse_t sb [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: sensors pass a SYNC-deep delay line, then a stability filter; the
  // filtered pattern is mapped to a position along the entry or exit track (0..3).
  bit [1:0]   q [$];
  int         run [2];
  bit [1:0]   m_filt;
  bit [1:0]   s;
  bit [1:0]   p;
  int         dir;   // 0 idle, 1 entering, 2 exiting, 3 blocked
  int         pos;
  int         n;
  logic [2:0] m_state;
  pulse_t     pe;

  function automatic int track_idx(input int d, input bit [1:0] pat);
    if (d == 1) begin
      case (pat)
        2'b10:   return 1;
        2'b11:   return 2;
        2'b01:   return 3;
        default: return 0;
      endcase
    end else begin
      case (pat)
        2'b01:   return 1;
        2'b11:   return 2;
        2'b10:   return 3;
        default: return 0;
      endcase
    end
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      for (int i = 0; i < SYNC; i++) q.push_back(2'b00);
      run[0] = 0;
      run[1] = 0;
      m_filt = 2'b00;
      dir = 0;
      pos = 0;
      m_state = 3'd0;
      sb.delete();
    end else begin
      cyc++;
      s = q[SYNC-1];
      p = m_filt;
      case (dir)
        0: begin
          if (p == 2'b10) begin dir = 1; pos = 1; end
          else if (p == 2'b01) begin dir = 2; pos = 1; end
          else if (p == 2'b11) dir = 3;
        end
        3: if (p == 2'b00) dir = 0;
        default: begin
          n = track_idx(dir, p);
          if (n != pos) begin
            if (n == 0 && pos == 1) dir = 0;
            else if (n == 0 && pos == 3) begin
              pe.cyc = cyc;
              pe.is_enter = (dir == 1);
              sb.push_back(pe);
              dir = 0;
            end else if (n >= 1 && (n == pos + 1 || n == pos - 1)) pos = n;
            else dir = 3;
          end
        end
      endcase
      for (int k = 0; k < 2; k++) begin
        if (s[k] != m_filt[k]) begin
          run[k]++;
          if (run[k] == DEB) begin
            m_filt[k] = s[k];
            run[k] = 0;
          end
        end else begin
          run[k] = 0;
        end
      end
      q.push_front({outer_raw, inner_raw});
      void'(q.pop_back());
      case (dir)
        0:       m_state = 3'd0;
        1:       m_state = 3'(pos);
        2:       m_state = 3'(pos + 3);
        default: m_state = 3'd7;
      endcase
    end
  end

  // Monitor: compares every cycle and consumes scoreboard entries as pulses fall due.
  int         n_enter = 0;
  int         n_exit = 0;
  int         last_enter_cyc = -1;
  int         n_outer_hi = 0;
  logic [2:0] prev_st = 3'd0;
  logic [2:0] vlog [$];
  bit         exp_en;
  bit         exp_ex;
  pulse_t     pm;

  always @(negedge clk) begin
    if (reset_n) begin
      check("leds_busy_state", {25'd0, outer_led, inner_led, busy, state_dbg},
            {25'd0, m_filt, (m_state != 3'd0), m_state});
      exp_en = 1'b0;
      exp_ex = 1'b0;
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        pm = sb.pop_front();
        check("missed_pulse_cycle", 32'(cyc), 32'(pm.cyc));
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        pm = sb.pop_front();
        exp_en = pm.is_enter;
        exp_ex = !pm.is_enter;
      end
      check("pulses", {30'd0, enter, exit}, {30'd0, exp_en, exp_ex});
      if (enter) begin n_enter++; last_enter_cyc = cyc; end
      if (exit) n_exit++;
      if (outer_led) n_outer_hi++;
      if (state_dbg != prev_st) vlog.push_back(state_dbg);
      prev_st = state_dbg;
    end else begin
      prev_st = 3'd0;
    end
  end

  task automatic hold(input bit [1:0] pat, input int cycles);
    {outer_raw, inner_raw} = pat;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic passage(input bit is_entry);
    bit [1:0] seq [4];
    if (is_entry) seq = '{2'b10, 2'b11, 2'b01, 2'b00};
    else          seq = '{2'b01, 2'b11, 2'b10, 2'b00};
    foreach (seq[i]) hold(seq[i], $urandom_range(5, 10));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, x0, c0, v0, h0;
    bit [1:0] rp;

    repeat (3) @(negedge clk);
    check("reset_outputs", {26'd0, enter, exit, outer_led, inner_led, busy, state_dbg[0]}, 32'd0);
    check("reset_state", {29'd0, state_dbg}, 32'd0);
    reset_n = 1'b1;
    hold(2'b00, 5);

    // 1: entry
    e0 = n_enter; x0 = n_exit;
    hold(2'b10, 10); hold(2'b11, 10); hold(2'b01, 10);
    c0 = cyc;
    hold(2'b00, 15);
    check("t1_enter_count", 32'(n_enter), 32'(e0 + 1));
    check("t1_exit_count", 32'(n_exit), 32'(x0));
    check("t1_latency", 32'(last_enter_cyc), 32'(c0 + SYNC + DEB + 1));

    // 2: exit, with state trace 4,5,6,0
    e0 = n_enter; x0 = n_exit; v0 = vlog.size();
    hold(2'b01, 10); hold(2'b11, 10); hold(2'b10, 10); hold(2'b00, 15);
    check("t2_exit_count", 32'(n_exit), 32'(x0 + 1));
    check("t2_enter_count", 32'(n_enter), 32'(e0));
    check("t2_visits", 32'(vlog.size() - v0), 32'd4);
    if (vlog.size() - v0 == 4)
      check("t2_trace", {20'd0, vlog[v0], vlog[v0+1], vlog[v0+2], vlog[v0+3]},
            {20'd0, 3'd4, 3'd5, 3'd6, 3'd0});

    // 3: back out
    e0 = n_enter; x0 = n_exit;
    hold(2'b10, 10); hold(2'b11, 10); hold(2'b10, 10); hold(2'b00, 15);
    check("t3_pulses", 32'(n_enter + n_exit), 32'(e0 + x0));
    check("t3_state", {29'd0, state_dbg}, 32'd0);

    // 4: short glitch on the outer beam
    h0 = n_outer_hi;
    hold(2'b10, 2); hold(2'b00, 12);
    check("t4_outer_led", 32'(n_outer_hi), 32'(h0));
    check("t4_state", {29'd0, state_dbg}, 32'd0);

    // 5: both beams blocked from idle
    e0 = n_enter; x0 = n_exit;
    hold(2'b11, 10);
    check("t5_block", {29'd0, state_dbg}, 32'd7);
    hold(2'b01, 10);
    check("t5_block_held", {29'd0, state_dbg}, 32'd7);
    hold(2'b00, 10);
    check("t5_idle", {29'd0, state_dbg}, 32'd0);
    check("t5_pulses", 32'(n_enter + n_exit), 32'(e0 + x0));

    // 6: reset in the middle of an entry
    hold(2'b10, 10); hold(2'b11, 10); hold(2'b01, 10);
    check("t6_in_en3", {29'd0, state_dbg}, 32'd3);
    e0 = n_enter;
    @(posedge clk);
    #2 reset_n = 1'b0;
    {outer_raw, inner_raw} = 2'b00;
    #1 check("t6_reset_outputs", {24'd0, enter, exit, outer_led, inner_led, busy, state_dbg}, 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    hold(2'b00, 15);
    check("t6_no_enter", 32'(n_enter), 32'(e0));
    check("t6_state", {29'd0, state_dbg}, 32'd0);

    // Random traffic: raw patterns of random length mixed with clean passages.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        passage($urandom_range(0, 1) == 1);
      end else begin
        rp = 2'($urandom_range(0, 3));
        hold(rp, $urandom_range(1, 12));
      end
    end
    hold(2'b00, 20);
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("final_idle", {29'd0, state_dbg}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
